// File: rtl/prm_scan_pkg.sv
// Shared types and helpers for the PRM edge scanner: FSM state encoding,
// default code width and the saturating counter step.
package prm_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } scan_state_e;

   localparam int CODE_W_DEF = 15;

   // Counter widths up to 32 bits are carried through this 32-bit helper.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/prm_edge_scan_acc.sv
// Stage-valid flag plus NUM_EDGE-wide OR accumulator with synchronous clear.
// With PRM_EDGE_SCAN_EARLY_EXIT_EN it also reports when the next value is all ones.
module prm_edge_scan_acc #(
   parameter int NUM_EDGE = 256
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                clr,
   input  logic                load,
   input  logic [NUM_EDGE-1:0] mask,
   output logic [NUM_EDGE-1:0] acc
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
  ,output logic                full
`endif
);

   logic                vld_q, vld_d;
   logic [NUM_EDGE-1:0] acc_q, acc_d;
   logic [NUM_EDGE-1:0] acc_next;

   // The reply for the staged code is only meaningful while vld_q is set.
   always_comb begin
      acc_next = vld_q ? (acc_q | mask) : acc_q;
      acc_d    = clr ? '0 : acc_next;
      vld_d    = load;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q <= 1'b0;
         acc_q <= '0;
      end else begin
         vld_q <= vld_d;
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
   // Looks ahead through the pending reply so the very next code can be frozen.
   assign full = &acc_next;
`endif

endmodule

// File: rtl/prm_edge_scan.sv
// PRM obstacle-check initiator: broadcasts obstacle codes, ORs edge replies into
// a collision bitmap. Optional early exit: PRM_EDGE_SCAN_EARLY_EXIT_EN.
module prm_edge_scan
   import prm_scan_pkg::*;
#(
   parameter int NUM_EDGE = 256,
   parameter int CODE_W   = CODE_W_DEF,
   parameter int CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                obs_valid,
   output logic                obs_ready,
   input  logic [CODE_W-1:0]   obs_code,
   input  logic                obs_last,
   output logic [CODE_W-1:0]   chk_code,
   input  logic [NUM_EDGE-1:0] chk_mask,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [NUM_EDGE-1:0] res_map,
   output logic [CNT_W-1:0]    res_count,
   output logic                busy
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
  ,output logic                saturated
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   scan_state_e       state_q, state_d;
   logic              obs_ready_q, obs_ready_d;
   logic              res_valid_q, res_valid_d;
   logic              busy_q, busy_d;
   logic [CODE_W-1:0] chk_code_q, chk_code_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              accept, frame_start, freeze, load;

   assign accept      = obs_valid & obs_ready_q;
   assign frame_start = accept & (state_q == IDLE);
   assign load        = accept & ~freeze;

`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
   logic acc_full;
   logic sat_q, sat_d;
   assign freeze = acc_full & (state_q == SCAN);
`else
   assign freeze = 1'b0;
`endif

   prm_edge_scan_acc #(.NUM_EDGE(NUM_EDGE)) u_acc (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (frame_start),
      .load (load),
      .mask (chk_mask),
      .acc  (res_map)
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
     ,.full (acc_full)
`endif
   );

   always_comb begin
      state_d     = state_q;
      obs_ready_d = obs_ready_q;
      res_valid_d = res_valid_q;
      busy_d      = busy_q;
      count_d     = count_q;
      chk_code_d  = load ? obs_code : chk_code_q;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
      sat_d       = sat_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               count_d = CNT_W'(1);
               busy_d  = 1'b1;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
               sat_d   = 1'b0;
`endif
               state_d     = obs_last ? FLUSH : SCAN;
               obs_ready_d = ~obs_last;
            end
         end
         SCAN: begin
            if (accept) begin
               count_d = CNT_W'(sat_inc(32'(count_q), 32'(CNT_MAX)));
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
               if (freeze) sat_d = 1'b1;
`endif
               if (obs_last) begin
                  state_d     = FLUSH;
                  obs_ready_d = 1'b0;
               end
            end
         end
         FLUSH: begin
            state_d     = DONE;
            res_valid_d = 1'b1;
         end
         DONE: begin
            if (res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               obs_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         obs_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         chk_code_q  <= '0;
         count_q     <= '0;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         obs_ready_q <= obs_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         chk_code_q  <= chk_code_d;
         count_q     <= count_d;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   assign obs_ready = obs_ready_q;
   assign res_valid = res_valid_q;
   assign res_count = count_q;
   assign chk_code  = chk_code_q;
   // busy covers the accepting cycle itself, before any flop has moved.
   assign busy      = busy_q | frame_start;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
   assign saturated = sat_q & res_valid_q;
`endif

   // Upstream must hold a stalled code and its last flag.
   obs_hold_a: assert property (@(posedge CLK) disable iff (RST)
      (obs_valid && !obs_ready_q) |=> (!obs_valid || ($stable(obs_code) && $stable(obs_last))));

endmodule

// File: tb/tb_prm_edge_scan.sv
// Bench for prm_edge_scan with NUM_EDGE=4, CNT_W=3 and a checker stub mask = code[3:0].
// Build with PRM_EDGE_SCAN_EARLY_EXIT_EN to also exercise the early-exit path.
module tb_prm_edge_scan;

   localparam int NE = 4;
   localparam int CW = 15;
   localparam int NW = 3;
   localparam int EW = 1 + NE + NW;

   logic          CLK = 1'b0;
   logic          RST;
   logic          obs_valid, obs_ready, obs_last;
   logic [CW-1:0] obs_code, chk_code;
   logic [NE-1:0] chk_mask, res_map;
   logic          res_valid, res_ready, busy;
   logic [NW-1:0] res_count;
   logic          sat_port;

   prm_edge_scan #(.NUM_EDGE(NE), .CODE_W(CW), .CNT_W(NW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .obs_valid (obs_valid),
      .obs_ready (obs_ready),
      .obs_code  (obs_code),
      .obs_last  (obs_last),
      .chk_code  (chk_code),
      .chk_mask  (chk_mask),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_map   (res_map),
      .res_count (res_count),
      .busy      (busy)
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
     ,.saturated (sat_port)
`endif
   );

`ifndef PRM_EDGE_SCAN_EARLY_EXIT_EN
   assign sat_port = 1'b0;
`endif

   assign chk_mask = chk_code[NE-1:0];

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;

   logic [EW-1:0] exp_q[$];
   logic [NE-1:0] m_map;
   logic [NW-1:0] m_cnt;
   logic          m_sat;
   logic          m_first = 1'b1;
   logic [CW-1:0] exp_chk = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference model of one accepted code; pushes the frame result on obs_last.
   task automatic model_accept(input logic [CW-1:0] code, input logic last);
      logic frozen;
      if (m_first) begin
         m_map = '0;
         m_cnt = '0;
         m_sat = 1'b0;
      end
      frozen = 1'b0;
`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
      frozen = !m_first && (&m_map);
`endif
      if (frozen) m_sat = 1'b1;
      else begin
         m_map   = m_map | code[NE-1:0];
         exp_chk = code;
      end
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      m_first = last;
      if (last) exp_q.push_back({m_sat, m_map, m_cnt});
   endtask

   task automatic send(input logic [CW-1:0] code, input logic last);
      int n;
      n = 0;
      obs_valid = 1'b1;
      obs_code  = code;
      obs_last  = last;
      @(negedge CLK);
      while (!obs_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!obs_ready) check_eq("send_timeout", 32'd0, 32'd1);
      tick();
      obs_valid = 1'b0;
      obs_last  = 1'b0;
      if (n < 50) model_accept(code, last);
   endtask

   // Scoreboard: broadcast code tracking and result pop on each handshake.
   always @(negedge CLK) begin
      logic [EW-1:0] e;
      if (!RST) begin
         check_eq("chk_code", 32'(chk_code), 32'(exp_chk));
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_result", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check_eq("res_map", 32'(res_map), 32'(e[NE+NW-1:NW]));
               check_eq("res_count", 32'(res_count), 32'(e[NW-1:0]));
               check_eq("saturated", 32'(sat_port), 32'(e[EW-1]));
            end
         end
      end
   end

   initial begin
      RST       = 1'b1;
      obs_valid = 1'b0;
      obs_code  = '0;
      obs_last  = 1'b0;
      res_ready = 1'b1;
      repeat (3) tick();
      RST = 1'b0;

      @(negedge CLK);
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_obs_ready", 32'(obs_ready), 32'd1);
      check_eq("rst_res_map", 32'(res_map), 32'd0);
      check_eq("rst_res_count", 32'(res_count), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      tick();

      // 1: reset in the middle of a frame discards it
      send(15'h0003, 1'b0);
      send(15'h0005, 1'b0);
      send(15'h0009, 1'b0);
      RST = 1'b1;
      tick();
      RST     = 1'b0;
      m_first = 1'b1;
      exp_chk = '0;
      @(negedge CLK);
      check_eq("t1_res_valid", 32'(res_valid), 32'd0);
      check_eq("t1_res_count", 32'(res_count), 32'd0);
      check_eq("t1_obs_ready", 32'(obs_ready), 32'd1);
      check_eq("t1_res_map", 32'(res_map), 32'd0);
      check_eq("t1_busy", 32'(busy), 32'd0);
      tick();

      // 2: back-to-back frame, 2-cycle latency to res_valid
      send(15'h0001, 1'b0);
      send(15'h0004, 1'b0);
      send(15'h0000, 1'b1);
      @(negedge CLK);
      check_eq("t2_lat1_valid", 32'(res_valid), 32'd0);
      check_eq("t2_flush_ready", 32'(obs_ready), 32'd0);
      @(negedge CLK);
      check_eq("t2_lat2_valid", 32'(res_valid), 32'd1);
      check_eq("t2_map", 32'(res_map), 32'b0101);
      check_eq("t2_count", 32'(res_count), 32'd3);
      tick();

      // 3: single-code frame, busy across accept/flush/done
      obs_valid = 1'b1;
      obs_code  = 15'h7FF8;
      obs_last  = 1'b1;
      @(negedge CLK);
      check_eq("t3_busy_t0", 32'(busy), 32'd1);
      check_eq("t3_ready_t0", 32'(obs_ready), 32'd1);
      tick();
      obs_valid = 1'b0;
      obs_last  = 1'b0;
      model_accept(15'h7FF8, 1'b1);
      @(negedge CLK);
      check_eq("t3_busy_t1", 32'(busy), 32'd1);
      check_eq("t3_valid_t1", 32'(res_valid), 32'd0);
      @(negedge CLK);
      check_eq("t3_busy_t2", 32'(busy), 32'd1);
      check_eq("t3_valid_t2", 32'(res_valid), 32'd1);
      @(negedge CLK);
      check_eq("t3_busy_t3", 32'(busy), 32'd0);
      check_eq("t3_ready_t3", 32'(obs_ready), 32'd1);
      tick();

      // 4: back-pressure in DONE with a code waiting upstream
      res_ready = 1'b0;
      send(15'h0003, 1'b0);
      send(15'h0004, 1'b1);
      tick();
      obs_valid = 1'b1;
      obs_code  = 15'h0008;
      obs_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check_eq("t4_hold_valid", 32'(res_valid), 32'd1);
         check_eq("t4_hold_map", 32'(res_map), 32'b0111);
         check_eq("t4_hold_count", 32'(res_count), 32'd2);
         check_eq("t4_hold_ready", 32'(obs_ready), 32'd0);
         tick();
      end
      obs_valid = 1'b0;
      obs_last  = 1'b0;
      res_ready = 1'b1;
      tick();
      send(15'h0008, 1'b1);
      repeat (3) tick();

      // 5: stalled stream of codes that all hit edge 1
      for (int i = 0; i < 6; i++) begin
         logic [CW-1:0] c;
         c = {CW'($urandom_range(0, 2047)) << 4} | CW'(4'b0010);
         send(c, i == 5);
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (4) tick();

      // counter saturation
      for (int i = 0; i < 9; i++) send(CW'($urandom_range(0, 32767)), i == 8);
      repeat (4) tick();

`ifdef PRM_EDGE_SCAN_EARLY_EXIT_EN
      // 6: early exit freezes the broadcast code once every edge is blocked
      send(15'h000F, 1'b0);
      send(15'h0001, 1'b0);
      check_eq("t6_chk_frozen1", 32'(chk_code), 32'h000F);
      send(15'h0002, 1'b1);
      check_eq("t6_chk_frozen2", 32'(chk_code), 32'h000F);
      repeat (4) tick();
`endif

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      check_eq("drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
